push_vc_demux: RTL and testbench



---
 rtl/push_vc_demux_pkg.sv | 10 +
 rtl/skid_buf2.sv | 42 ++++
 rtl/push_vc_demux.sv | 64 ++++++
 tb/tb_push_vc_demux.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/push_vc_demux_pkg.sv
// Shared constants and VC encoding for the ingress-to-VC write path.
package push_vc_demux_pkg;
  localparam int DATA_WIDTH_DEF = 6;
  localparam int VC_BIT_DEF     = 4;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_e;
endpackage

// File: rtl/skid_buf2.sv
// Two-entry synchronous FIFO used to absorb a one-cycle read latency.
module skid_buf2
  import push_vc_demux_pkg::*;
#(
  parameter int W = DATA_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/push_vc_demux.sv
// Drains the main ingress FIFO and steers each word, in order, into the VC0 or VC1 FIFO.
module push_vc_demux
  import push_vc_demux_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int VC_BIT     = VC_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  main_empty,
  input  logic [DATA_WIDTH-1:0] main_data,
  output logic                  main_read,
  input  logic                  vc0_full,
  input  logic                  vc1_full,
  input  logic                  vc0_almost_full,
  input  logic                  vc1_almost_full,
  output logic                  vc0_push,
  output logic [DATA_WIDTH-1:0] vc0_data,
  output logic                  vc1_push,
  output logic [DATA_WIDTH-1:0] vc1_data,
  output logic                  pause
);
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] head;
  logic                  rd_pending;
  logic                  pop_now;
  logic                  head_full;
  logic [2:0]            occupancy;
  vc_e                   head_vc;

  skid_buf2 #(.W(DATA_WIDTH)) u_buf (
    .clk       (clk),
    .rst       (reset),
    .push      (rd_pending),
    .push_data (main_data),
    .pop       (pop_now),
    .count     (count),
    .head      (head)
  );

  // Handshake: a push is accepted whenever the target's full is low in the same
  // cycle; main_read is a credit-checked pop whose data arrives one cycle later.
  always_comb begin
    head_vc   = vc_e'(head[VC_BIT]);
    head_full = (head_vc == VC1) ? vc1_full : vc0_full;
    pop_now   = !reset && (count != 2'd0) && !head_full;
    occupancy = {1'b0, count} + {2'b00, rd_pending} - {2'b00, pop_now};
    main_read = !reset && !main_empty && !pause && (occupancy < 3'd2);
    vc0_push  = pop_now && (head_vc == VC0);
    vc1_push  = pop_now && (head_vc == VC1);
    vc0_data  = (count != 2'd0) ? head : '0;
    vc1_data  = (count != 2'd0) ? head : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pending <= 1'b0;
      pause      <= 1'b0;
    end else begin
      rd_pending <= main_read;
      pause      <= vc0_almost_full | vc1_almost_full;
    end
  end
endmodule

// File: tb/tb_push_vc_demux.sv
// Self-checking bench for push_vc_demux: directed scenarios plus a randomized run.
module tb_push_vc_demux;
  localparam int DW  = 6;
  localparam int VCB = 4;

  typedef struct {
    int            cyc;
    bit            vc;
    logic [DW-1:0] d;
  } push_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          main_empty = 1'b1;
  logic [DW-1:0] main_data = '0;
  logic          main_read;
  logic          vc0_full = 1'b0, vc1_full = 1'b0;
  logic          vc0_almost_full = 1'b0, vc1_almost_full = 1'b0;
  logic          vc0_push, vc1_push, pause;
  logic [DW-1:0] vc0_data, vc1_data;

  push_vc_demux #(.DATA_WIDTH(DW), .VC_BIT(VCB)) dut (
    .clk             (clk),
    .reset           (reset),
    .main_empty      (main_empty),
    .main_data       (main_data),
    .main_read       (main_read),
    .vc0_full        (vc0_full),
    .vc1_full        (vc1_full),
    .vc0_almost_full (vc0_almost_full),
    .vc1_almost_full (vc1_almost_full),
    .vc0_push        (vc0_push),
    .vc0_data        (vc0_data),
    .vc1_push        (vc1_push),
    .vc1_data        (vc1_data),
    .pause           (pause)
  );

  // environment + model state
  logic [DW-1:0] main_q[$];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] mbuf[$];
  bit            mpend = 0;
  bit            mpause = 0;
  bit            rd_seen = 0;
  push_t         log_q[$];
  int            cyc = 0;
  int            first_rd = -1;
  int            rd_cnt = 0;
  int            pause_cyc = 0;
  int            push_in_pause = 0;
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event with empty expectation, expected none (cycle %0d)", name, cyc);
  endtask

  // Per-cycle compare against the model, then advance the model across the edge.
  task automatic check_cycle();
    logic [DW-1:0] hd;
    bit hvc, e_pop, e_read;
    int occ;
    if (reset) begin
      chk("rst_main_read", main_read, 0);
      chk("rst_vc0_push", vc0_push, 0);
      chk("rst_vc1_push", vc1_push, 0);
      chk("rst_vc0_data", vc0_data, 0);
      chk("rst_vc1_data", vc1_data, 0);
      chk("rst_pause", pause, 0);
      mbuf.delete();
      exp_q0.delete();
      exp_q1.delete();
      mpend = 0;
      mpause = 0;
      rd_seen = 0;
      return;
    end
    hd     = (mbuf.size() > 0) ? mbuf[0] : '0;
    hvc    = hd[VCB];
    e_pop  = (mbuf.size() > 0) && !(hvc ? vc1_full : vc0_full);
    occ    = mbuf.size() + int'(mpend) - int'(e_pop);
    e_read = !main_empty && !mpause && (occ < 2);
    chk("main_read", main_read, e_read);
    chk("vc0_push", vc0_push, e_pop && !hvc);
    chk("vc1_push", vc1_push, e_pop && hvc);
    chk("vc0_data", vc0_data, hd);
    chk("vc1_data", vc1_data, hd);
    chk("pause", pause, mpause);
    chk("one_hot_push", vc0_push & vc1_push, 0);
    if (main_read) chk("credit", (occ < 2), 1);
    if (vc0_push) begin
      if (exp_q0.size() == 0) fail_now("sb_vc0");
      else chk("sb_vc0", vc0_data, exp_q0.pop_front());
      log_q.push_back('{cyc, 1'b0, vc0_data});
    end
    if (vc1_push) begin
      if (exp_q1.size() == 0) fail_now("sb_vc1");
      else chk("sb_vc1", vc1_data, exp_q1.pop_front());
      log_q.push_back('{cyc, 1'b1, vc1_data});
    end
    if (pause) begin
      pause_cyc++;
      if (vc0_push || vc1_push) push_in_pause++;
    end
    if (main_read) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (e_pop) void'(mbuf.pop_front());
    if (mpend) mbuf.push_back(main_data);
    mpend   = e_read;
    mpause  = vc0_almost_full | vc1_almost_full;
    rd_seen = main_read;
  endtask

  // driver: one clock cycle; inputs change only #1 after the rising edge
  task automatic step();
    logic [DW-1:0] w;
    main_empty = (main_q.size() == 0);
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_seen) begin
      if (main_q.size() == 0) begin
        fail_now("read_of_empty_main");
        main_data = DW'($urandom);
      end else begin
        w = main_q.pop_front();
        main_data = w;
        if (w[VCB]) exp_q1.push_back(w);
        else        exp_q0.push_back(w);
      end
    end else begin
      main_data = DW'($urandom);
    end
    main_empty = (main_q.size() == 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_stats();
    log_q.delete();
    first_rd = -1;
    rd_cnt = 0;
    pause_cyc = 0;
    push_in_pause = 0;
  endtask

  initial begin
    #2 reset = 1'b1;
    steps(2);
    reset = 1'b0;
    steps(2);

    // basic routing and first-push latency
    clear_stats();
    main_q.push_back(6'h05); main_q.push_back(6'h15); main_q.push_back(6'h02);
    steps(8);
    chk("route_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("route_latency", log_q[0].cyc, first_rd + 2);
      chk("route0_vc", log_q[0].vc, 0);  chk("route0_d", log_q[0].d, 6'h05);
      chk("route1_vc", log_q[1].vc, 1);  chk("route1_d", log_q[1].d, 6'h15);
      chk("route1_cyc", log_q[1].cyc, first_rd + 3);
      chk("route2_vc", log_q[2].vc, 0);  chk("route2_d", log_q[2].d, 6'h02);
      chk("route2_cyc", log_q[2].cyc, first_rd + 4);
    end

    // head-of-line blocking
    clear_stats();
    vc1_full = 1'b1;
    main_q.push_back(6'h10); main_q.push_back(6'h01); main_q.push_back(6'h03);
    steps(8);
    chk("hol_no_push", log_q.size(), 0);
    chk("hol_reads", rd_cnt, 2);
    vc1_full = 1'b0;
    steps(8);
    chk("hol_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("hol0_vc", log_q[0].vc, 1);  chk("hol0_d", log_q[0].d, 6'h10);
      chk("hol1_d", log_q[1].d, 6'h01);
      chk("hol2_d", log_q[2].d, 6'h03);
    end

    // almost-full pause
    clear_stats();
    for (int i = 1; i <= 6; i++) main_q.push_back(DW'(i));
    step();
    vc0_almost_full = 1'b1;
    steps(3);
    vc0_almost_full = 1'b0;
    steps(12);
    chk("pause_cycles", pause_cyc, 3);
    chk("pause_drain", (push_in_pause > 0), 1);
    chk("pause_all_out", log_q.size(), 6);

    // empty boundary: single word
    clear_stats();
    main_q.push_back(6'h07);
    steps(6);
    chk("empty_reads", rd_cnt, 1);
    chk("empty_push", log_q.size(), 1);
    if (log_q.size() == 1) chk("empty_d", log_q[0].d, 6'h07);

    // reset with the buffer full
    clear_stats();
    vc0_full = 1'b1;
    vc1_full = 1'b1;
    main_q.push_back(6'h01); main_q.push_back(6'h02); main_q.push_back(6'h03);
    steps(6);
    chk("rst_pre_reads", rd_cnt, 2);
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    vc0_full = 1'b0;
    vc1_full = 1'b0;
    clear_stats();
    steps(6);
    chk("rst_resume_reads", rd_cnt, 1);
    chk("rst_resume_push", log_q.size(), 1);
    if (log_q.size() == 1) chk("rst_resume_d", log_q[0].d, 6'h03);

    // randomized run
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 1 && main_q.size() < 8) main_q.push_back(DW'($urandom_range(0, 63)));
      vc0_full        = ($urandom_range(0, 3) == 0);
      vc1_full        = ($urandom_range(0, 3) == 0);
      vc0_almost_full = ($urandom_range(0, 9) == 0);
      vc1_almost_full = ($urandom_range(0, 9) == 0);
      step();
    end
    vc0_full = 1'b0;
    vc1_full = 1'b0;
    vc0_almost_full = 1'b0;
    vc1_almost_full = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (main_q.size() == 0 && exp_q0.size() == 0 && exp_q1.size() == 0 && mbuf.size() == 0 && !mpend) break;
      step();
    end
    chk("drain_main", main_q.size(), 0);
    chk("drain_vc0", exp_q0.size(), 0);
    chk("drain_vc1", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
